nec_ir_decoder: RTL

Parametrised NEC infrared frame decoder for the snake game's remote-control input path. It samples the demodulated IR receiver output on the slow `nec_clk` tick clock, measures mark and space durations against configurable windows, and assembles 32-bit frames. It validates the command byte against its inverse and delivers each good frame with a one-cycle strobe, plus an optional repeat-code strobe for held keys. Downstream, the direction-mapping logic consumes `word`/`cmd` on `frame_valid`.

---
 rtl/nec_ir_decoder.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/nec_ir_decoder.sv
// NEC infrared frame decoder: measures mark/space widths in nec_clk ticks and assembles 32-bit frames.
// Define NEC_REPEAT_EN to compile in repeat-code support (REPEAT_MARK path, have_last, idle timeout).
module nec_ir_decoder #(
    parameter int LEAD_LOW_TICKS       = 160,
    parameter int LEAD_HIGH_TICKS      = 80,
    parameter int REPEAT_HIGH_TICKS    = 40,
    parameter int MARK_TICKS           = 10,
    parameter int ONE_THRESH           = 20,
    parameter int SPACE_MAX            = 35,
    parameter int TOL                  = 5,
    parameter int REPEAT_TIMEOUT_TICKS = 2200,
    parameter int ADDR_CHECK           = 0
) (
    input  logic        nec_clk,
    input  logic        reset_n,
    input  logic        ir_signal,
    output logic [31:0] word,
    output logic [7:0]  addr,
    output logic [7:0]  cmd,
    output logic        frame_valid,
    output logic        repeat_valid,
    output logic        error,
    output logic [1:0]  err_code,
    output logic        busy
);
    localparam int CNT_REF = (LEAD_LOW_TICKS + TOL > REPEAT_TIMEOUT_TICKS) ?
                             LEAD_LOW_TICKS + TOL : REPEAT_TIMEOUT_TICKS;
    localparam int CW = $clog2(CNT_REF + 2);

    localparam logic [CW-1:0] LL_MIN  = CW'(LEAD_LOW_TICKS - TOL);
    localparam logic [CW-1:0] LL_MAX  = CW'(LEAD_LOW_TICKS + TOL);
    localparam logic [CW-1:0] LH_MIN  = CW'(LEAD_HIGH_TICKS - TOL);
    localparam logic [CW-1:0] LH_MAX  = CW'(LEAD_HIGH_TICKS + TOL);
    localparam logic [CW-1:0] RP_MIN  = CW'(REPEAT_HIGH_TICKS - TOL);
    localparam logic [CW-1:0] RP_MAX  = CW'(REPEAT_HIGH_TICKS + TOL);
    localparam logic [CW-1:0] MK_MAX  = CW'(MARK_TICKS + TOL);
    localparam logic [CW-1:0] ONE_T   = CW'(ONE_THRESH);
    localparam logic [CW-1:0] SP_MAX  = CW'(SPACE_MAX);
    localparam logic [CW-1:0] CNT_SAT = {CW{1'b1}};
`ifdef NEC_REPEAT_EN
    localparam logic [CW-1:0] RPT_TO  = CW'(REPEAT_TIMEOUT_TICKS);
`endif

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_LEAD_LOW    = 3'd1;
    localparam logic [2:0] S_LEAD_SPACE  = 3'd2;
    localparam logic [2:0] S_BIT_MARK    = 3'd3;
    localparam logic [2:0] S_BIT_SPACE   = 3'd4;
    localparam logic [2:0] S_STOP_MARK   = 3'd5;
`ifdef NEC_REPEAT_EN
    localparam logic [2:0] S_REPEAT_MARK = 3'd6;
`endif

    logic          sync1, sync2, prev;
    logic          rise, fall;
    logic [2:0]    state, nxt;
    logic [CW-1:0] cnt;
    logic [5:0]    bit_cnt;
    logic [31:0]   shift;
    logic          err, pass, shift_en;
    logic [1:0]    err_c;
    logic          fv_p, er_p;
    logic [1:0]    code_p;
    logic          in_ll, in_lh, in_rp, mark_ok, mark_over, chk_ok;
`ifdef NEC_REPEAT_EN
    logic          rep, rv_p, have_last;
`endif

    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;

    assign in_ll     = (cnt >= LL_MIN) && (cnt <= LL_MAX);
    assign in_lh     = (cnt >= LH_MIN) && (cnt <= LH_MAX);
    assign in_rp     = (cnt >= RP_MIN) && (cnt <= RP_MAX);
    assign mark_ok   = (cnt != '0) && (cnt <= MK_MAX);
    assign mark_over = (cnt > MK_MAX);
    assign chk_ok    = (shift[15:8] == ~shift[7:0]) &&
                       ((ADDR_CHECK == 0) || (shift[31:24] == ~shift[23:16]));

    // Timeouts are tested before edges so an edge on the timeout cycle is dropped.
    always_comb begin
        nxt      = state;
        err      = 1'b0;
        err_c    = 2'd0;
        pass     = 1'b0;
        shift_en = 1'b0;
`ifdef NEC_REPEAT_EN
        rep      = 1'b0;
`endif
        case (state)
            S_IDLE:       if (fall) nxt = S_LEAD_LOW;
            S_LEAD_LOW: begin
                if (cnt > LL_MAX || (rise && !in_ll)) err = 1'b1;
                else if (rise)                        nxt = S_LEAD_SPACE;
            end
            S_LEAD_SPACE: begin
                if (cnt > LH_MAX) err = 1'b1;
                else if (fall) begin
                    if (in_lh)      nxt = S_BIT_MARK;
`ifdef NEC_REPEAT_EN
                    else if (in_rp) nxt = S_REPEAT_MARK;
`else
                    else if (in_rp) err = 1'b1;  // repeat leaders unsupported in this build
`endif
                    else            err = 1'b1;
                end
            end
            S_BIT_MARK: begin
                if (mark_over || (rise && !mark_ok)) err = 1'b1;
                else if (rise)                       nxt = S_BIT_SPACE;
            end
            S_BIT_SPACE: begin
                if (cnt >= SP_MAX) err = 1'b1;
                else if (fall) begin
                    shift_en = 1'b1;
                    nxt      = (bit_cnt == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
                end
            end
            S_STOP_MARK: begin
                if (mark_over || (rise && !mark_ok)) err = 1'b1;
                else if (rise) begin
                    nxt = S_IDLE;
                    if (chk_ok) pass = 1'b1;
                    else begin
                        err   = 1'b1;
                        err_c = 2'd1;
                    end
                end
            end
`ifdef NEC_REPEAT_EN
            S_REPEAT_MARK: begin
                if (mark_over || (rise && !mark_ok)) err = 1'b1;
                else if (rise) begin
                    nxt = S_IDLE;
                    if (have_last) rep = 1'b1;
                    else begin
                        err   = 1'b1;
                        err_c = 2'd2;
                    end
                end
            end
`endif
            default:      nxt = S_IDLE;
        endcase
        if (err) nxt = S_IDLE;
    end

    always_ff @(posedge nec_clk) begin
        if (!reset_n) begin
            sync1        <= 1'b1;
            sync2        <= 1'b1;
            prev         <= 1'b1;
            state        <= S_IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            fv_p         <= 1'b0;
            er_p         <= 1'b0;
            code_p       <= 2'd0;
            word         <= '0;
            frame_valid  <= 1'b0;
            error        <= 1'b0;
            err_code     <= 2'd0;
`ifdef NEC_REPEAT_EN
            rv_p         <= 1'b0;
            have_last    <= 1'b0;
            repeat_valid <= 1'b0;
`endif
        end else begin
            sync1 <= ir_signal;
            sync2 <= sync1;
            prev  <= sync2;
            state <= nxt;

            if (nxt != state)      cnt <= '0;
            else if (cnt != CNT_SAT) cnt <= cnt + 1'b1;

            if (state == S_LEAD_SPACE && nxt == S_BIT_MARK) bit_cnt <= '0;
            else if (shift_en)                               bit_cnt <= bit_cnt + 6'd1;
            if (shift_en) shift <= {shift[30:0], cnt >= ONE_T};

            // Decision stage, then output stage: strobes land 3 ticks after the edge is sampled.
            fv_p <= pass;
            er_p <= err;
            if (err) code_p <= err_c;

            frame_valid <= fv_p;
            error       <= er_p;
            if (er_p) err_code <= code_p;
            if (fv_p) word     <= shift;
`ifdef NEC_REPEAT_EN
            rv_p         <= rep;
            repeat_valid <= rv_p;
            if (err)                                        have_last <= 1'b0;
            else if (pass)                                  have_last <= 1'b1;
            else if (state == S_IDLE && cnt >= RPT_TO)      have_last <= 1'b0;
`endif
        end
    end

`ifndef NEC_REPEAT_EN
    assign repeat_valid = 1'b0;
`endif

    assign addr = word[31:24];
    assign cmd  = word[15:8];
    assign busy = (state != S_IDLE);
endmodule
